sensor_conditioner: RTL
=======================

# sensor_conditioner

Upstream front end for the highway/country signal controller. Conditions the raw country-road loop-detector input into the clean car-waiting request `x` that the controller samples every cycle:
- synchronises and debounces the detector;
- counts queued vehicles;
- holds the request long enough for the controller to act on short arrivals.

It also watches the controller's country-light output so it can retire vehicles served during country green.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required to accept a level change (≥1).
- `HOLD_CYCLES`, default 8: minimum `x` assertion after each accepted arrival (≥1).
- `CNT_W`, default 4: width of the vehicle queue counter.

Ports:
- `clock`, input, 1: single clock; all state on its rising edge.
- `clear`, input, 1: reset, asynchronous, active-high.
- `raw_sensor`, input, 1: asynchronous loop-detector level, 1 = vehicle present.
- `cntry`, input, 2: country light code from the controller (`RED`=01, `YELLOW`=10, `GREEN`=11).
- `x`, output, 1: conditioned vehicle request to the controller.
- `car_count`, output, `CNT_W`: vehicles queued on the country road.
- `overflow`, output, 1: sticky flag, an arrival was seen while `car_count` was at its maximum.

## Operation
- **Synchroniser:** `raw_sensor` passes through a 2-flop synchroniser; its output is `s2`.
- **Debounce FSM** (one counter `dcnt`), states:
  - `LOW`: moves to `QUAL_H` when `s2`=1.
  - `QUAL_H`: `dcnt` increments while `s2`=1; returns to `LOW` and zeroes `dcnt` on `s2`=0; moves to `HIGH` when `dcnt` reaches `DEBOUNCE_CYCLES`.
  - `HIGH`: moves to `QUAL_L` when `s2`=0.
  - `QUAL_L`: mirror of `QUAL_H`, returning to `HIGH` on `s2`=1 and moving to `LOW` when `dcnt` reaches `DEBOUNCE_CYCLES`.
  - Debounced level `db` = 1 in `HIGH` and `QUAL_L`.
- **Arrival:** the cycle `db` goes 0→1 is an arrival.
  - `car_count` increments, saturating at 2^CNT_W−1.
  - An arrival at saturation sets `overflow`, which stays set until `clear`.
  - `hold` is loaded with `HOLD_CYCLES`.
- **Departure:** the cycle `db` goes 1→0 while `cntry`==`GREEN` is a departure. `car_count` decrements, floored at 0.
  - A falling edge under any other `cntry` value has no effect on `car_count`.
- **Simultaneous events:** an arrival and a departure cannot occur in the same cycle.
- **Hold timer:** `hold` decrements by 1 per cycle while nonzero. An arrival reloads it regardless of its current value.
- **Request:** `x` = (`car_count`≠0) | (`hold`≠0). It is decoded from registers only; there is no combinational path from `raw_sensor` or `cntry`.
- **Illegal `cntry`:** code 00 is treated as not green.

## Timing
- **Reset:** with `clear` high, all registers clear immediately, regardless of clock:
  - synchroniser = 0, FSM = `LOW`, `dcnt` = 0, `hold` = 0;
  - outputs: `car_count` = 0, `overflow` = 0, `x` = 0.
- **Reset mid-qualification:** asserting `clear` during qualification discards the pending change.
- **Rising-change latency:** `raw_sensor` is first sampled high at edge N and stays high. Then `db`, `car_count`, `hold` and `x` all update at edge N+1+`DEBOUNCE_CYCLES`.
- **Falling-change latency:** identical to the rising case.
- **Rejected glitches:** a pulse on `s2` shorter than `DEBOUNCE_CYCLES` cycles produces no change in `db`.
- **Hold-only request:** with `car_count`=0, `x` deasserts exactly `HOLD_CYCLES` edges after the arrival edge.
- **Departure timing:** `cntry` is sampled at the same edge the departure is accepted.

## Configuration
- `SENSOR_COUNT_EN` defined:
  - queue counter and `overflow` are present;
  - `x` = (`car_count`≠0) | (`hold`≠0).
- `SENSOR_COUNT_EN` undefined:
  - no counter logic; `car_count` tied 0 and `overflow` tied 0;
  - `x` = `db` | (`hold`≠0), so a stationary vehicle keeps the request asserted.
  - Debounce and hold behaviour is unchanged.

## Structure
- Shared package `sig_pkg` holds:
  - light codes `RED`/`YELLOW`/`GREEN`, also used by the controller;
  - the debounce state enum (`LOW`, `QUAL_H`, `HIGH`, `QUAL_L`).
- One sub-module, `sync2`: 2-flop synchroniser with async active-high clear. It is reused wherever the design ingests asynchronous inputs.
- Debounce FSM, counter and hold timer live in `sensor_conditioner`.

## Test plan
Defaults assumed (`DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=8, `CNT_W`=4), `SENSOR_COUNT_EN` defined unless stated.
- **Glitch rejection:** `raw_sensor` high for 3 cycles, then low → `db` never rises; `x`=0 and `car_count`=0 throughout.
- **Single arrival:** `raw_sensor` first sampled high at edge 10 and held → at edge 15, `x`=1, `car_count`=1 and `hold`=8.
- **Departure:** raise `raw_sensor` then drop it with `cntry`=`RED` → `car_count` stays 1. Repeat the arrival, then drop `raw_sensor` with `cntry`=`GREEN` → `car_count` 2→1 at edge drop+5.
- **Saturation:** 16 arrivals with `cntry`=`RED` → `car_count`=15 and `overflow`=1. Further arrivals leave `car_count` at 15. Departure at 0 keeps `car_count`=0.
- **Reset mid-qualification:** assert `clear` while in `QUAL_H` (`dcnt`=2) → outputs are 0 immediately. After release, `raw_sensor` still high → a new arrival is accepted 5 edges later.
- **Counter compiled out:** `SENSOR_COUNT_EN` undefined, vehicle present 20 cycles → `x` high from acceptance until `db` falls or `hold` expires, whichever is later. `car_count` and `overflow` stay 0.

Source files
------------

// File: rtl/sig_pkg.sv
// Shared definitions for the signal controller and its sensor front end:
// country/highway light codes and the detector debounce state encoding.
package sig_pkg;

    localparam logic [1:0] RED    = 2'b01;
    localparam logic [1:0] YELLOW = 2'b10;
    localparam logic [1:0] GREEN  = 2'b11;

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        QUAL_H = 2'd1,
        HIGH   = 2'd2,
        QUAL_L = 2'd3
    } db_state_t;

endpackage

// File: rtl/sensor_conditioner_sync2.sv
// Two-flop synchroniser for asynchronous level inputs, one chain per bit,
// with an asynchronous active-high clear.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_reg[gi] <= 1'b0;
                    sync_reg[gi] <= 1'b0;
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule

// File: rtl/sensor_conditioner.sv
// Country-road loop detector conditioning: synchronise, debounce, count queued
// vehicles and stretch the request x. Queue counting is built only when
// SENSOR_COUNT_EN is defined; otherwise x follows the debounced level plus hold.
module sensor_conditioner
    import sig_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int CNT_W           = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             raw_sensor,
    input  logic [1:0]       cntry,
    output logic             x,
    output logic [CNT_W-1:0] car_count,
    output logic             overflow
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HLOAD = HW'(HOLD_CYCLES);

    logic          s2;
    db_state_t     state_reg;
    logic [DW-1:0] dcnt_reg;
    logic [HW-1:0] hold_reg;
    logic          db;
    logic          last;
    logic          rise;

    sync2 #(.WIDTH(1)) u_sync (
        .clk (clock),
        .rst (clear),
        .d   (raw_sensor),
        .q   (s2)
    );

    // dcnt counts stable samples already seen; the sample that makes it
    // DEBOUNCE_CYCLES is the accepting one, so LOW/HIGH accept at once when it is 1.
    assign last = (dcnt_reg == DLAST);
    assign db   = (state_reg == HIGH) || (state_reg == QUAL_L);
    assign rise = !db && s2 && last;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_reg <= LOW;
            dcnt_reg  <= '0;
        end else begin
            case (state_reg)
                LOW: begin
                    if (s2) begin
                        if (last) begin
                            state_reg <= HIGH;
                        end else begin
                            state_reg <= QUAL_H;
                            dcnt_reg  <= dcnt_reg + 1'b1;
                        end
                    end
                end
                QUAL_H: begin
                    if (!s2) begin
                        state_reg <= LOW;
                        dcnt_reg  <= '0;
                    end else if (last) begin
                        state_reg <= HIGH;
                        dcnt_reg  <= '0;
                    end else begin
                        dcnt_reg <= dcnt_reg + 1'b1;
                    end
                end
                HIGH: begin
                    if (!s2) begin
                        if (last) begin
                            state_reg <= LOW;
                        end else begin
                            state_reg <= QUAL_L;
                            dcnt_reg  <= dcnt_reg + 1'b1;
                        end
                    end
                end
                QUAL_L: begin
                    if (s2) begin
                        state_reg <= HIGH;
                        dcnt_reg  <= '0;
                    end else if (last) begin
                        state_reg <= LOW;
                        dcnt_reg  <= '0;
                    end else begin
                        dcnt_reg <= dcnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= LOW;
                    dcnt_reg  <= '0;
                end
            endcase
        end
    end

    // Every accepted arrival restarts the minimum request window.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            hold_reg <= '0;
        end else if (rise) begin
            hold_reg <= HLOAD;
        end else if (hold_reg != '0) begin
            hold_reg <= hold_reg - 1'b1;
        end
    end

`ifdef SENSOR_COUNT_EN
    logic             fall;
    logic [CNT_W-1:0] car_count_reg;
    logic             overflow_reg;

    assign fall = db && !s2 && last;

    // Only a vehicle leaving during country green has been served.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            car_count_reg <= '0;
            overflow_reg  <= 1'b0;
        end else if (rise) begin
            if (&car_count_reg) begin
                overflow_reg <= 1'b1;
            end else begin
                car_count_reg <= car_count_reg + 1'b1;
            end
        end else if (fall && (cntry == GREEN) && (car_count_reg != '0)) begin
            car_count_reg <= car_count_reg - 1'b1;
        end
    end

    assign car_count = car_count_reg;
    assign overflow  = overflow_reg;
    assign x         = (car_count_reg != '0) || (hold_reg != '0);
`else
    logic unused_cntry;

    assign unused_cntry = ^cntry;
    assign car_count    = '0;
    assign overflow     = 1'b0;
    assign x            = db || (hold_reg != '0);
`endif

endmodule
